// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter for a snooping bus: grants one processor at a time, broadcasts its op,
// resolves snoop abort/writeback, and falls back to a memory read when no snooper supplies data.
module snoop_bus_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [11:0] req_op,
  output logic [3:0]  grant,
  output logic        bus_valid,
  output logic [2:0]  bus_op,
  output logic [1:0]  bus_owner,
  input  logic        snoop_wb,
  input  logic        snoop_abort,
  input  logic [7:0]  snoop_data,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        mem_wr,
  output logic [3:0]  done,
  output logic [7:0]  data_out
);

  typedef enum logic [2:0] {
    StIdle,
    StBroadcast,
    StSnoop,
    StMemWait,
    StComplete
  } state_e;

  localparam logic [2:0] OpReadMiss  = 3'b001;
  localparam logic [2:0] OpWriteMiss = 3'b010;
  localparam logic [2:0] OpInval     = 3'b011;

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  bus_owner_q, bus_owner_d;
  logic [7:0]  data_q, data_d;
  logic        wb_q, wb_d;

  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;
  logic [2:0]  pick_op;
  logic        pick_legal;

  // Scan offsets 4..1 so the closest requester after last_q is the final assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    cand       = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_op    = req_op[3*int'(pick_idx) +: 3];
  assign pick_legal = (pick_op == OpReadMiss) || (pick_op == OpWriteMiss) ||
                      (pick_op == OpInval);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    last_d      = last_q;
    bus_owner_d = bus_owner_q;
    data_d      = data_q;
    wb_d        = wb_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          op_d    = pick_op;
          wb_d    = 1'b0;
          if (pick_legal) begin
            state_d     = StBroadcast;
            bus_owner_d = pick_idx;
          end else begin
            state_d = StComplete;
          end
        end
      end
      StBroadcast: state_d = StSnoop;
      StSnoop: begin
        if (op_q == OpInval) begin
          state_d = StComplete;
        end else if (snoop_abort) begin
          data_d  = snoop_data;
          wb_d    = snoop_wb;
          state_d = StComplete;
        end else begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        if (mem_ack) begin
          data_d  = mem_data;
          state_d = StComplete;
        end
      end
      StComplete: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      owner_q     <= 2'd0;
      op_q        <= 3'd0;
      last_q      <= 2'd3;
      bus_owner_q <= 2'd0;
      data_q      <= 8'h00;
      wb_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      last_q      <= last_d;
      bus_owner_q <= bus_owner_d;
      data_q      <= data_d;
      wb_q        <= wb_d;
    end
  end

  logic [3:0] owner_oh;
  assign owner_oh = 4'b0001 << owner_q;

  always_comb begin
    grant     = 4'b0000;
    bus_valid = 1'b0;
    bus_op    = 3'b000;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    done      = 4'b0000;
    if (state_q != StIdle) grant = owner_oh;
    if (state_q == StBroadcast) begin
      bus_valid = 1'b1;
      bus_op    = op_q;
    end
    if (state_q == StMemWait) mem_req = 1'b1;
    if (state_q == StComplete) begin
      done   = owner_oh;
      mem_wr = wb_q;
    end
  end

  assign bus_owner = bus_owner_q;
  assign data_out  = data_q;

endmodule

// File: doc/snoop_bus_arbiter.md
SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 clock  in  1  single system clock; all state changes on rising edge.
REQ-002 reset_n  in  1  reset, synchronous, active-low.
REQ-003 req  in  4  per-processor bus request, level, bit i = processor i.
REQ-004 req_op  in  12  packed ops, bits [3i+2:3i] = op of processor i: 001 read miss, 010 write miss, 011 invalidate.
REQ-005 grant  out  4  one-hot owner of current transaction.
REQ-006 bus_valid  out  1  snoop broadcast strobe.
REQ-007 bus_op  out  3  broadcast op.
REQ-008 bus_owner  out  2  broadcast processor index.
REQ-009 snoop_wb  in  1  OR of snoopers' writeback_block.
REQ-010 snoop_abort  in  1  OR of snoopers' abort_mem_accs.
REQ-011 snoop_data  in  8  block supplied by the aborting snooper.
REQ-012 mem_req  out  1  memory read request.
REQ-013 mem_ack  in  1  memory read data valid.
REQ-014 mem_data  in  8  memory read data.
REQ-015 mem_wr  out  1  memory writeback strobe; write data = data_out.
REQ-016 done  out  4  one-hot one-cycle completion pulse to owner.
REQ-017 data_out  out  8  block returned to owner; valid while done asserted.

Function
REQ-018 FSM states: IDLE, BROADCAST, SNOOP, MEM_WAIT, COMPLETE; exactly one active.
REQ-019 IDLE: if any req bit set, SHALL pick owner round-robin, searching from last_owner+1 mod 4 upward; latch owner and its op; req sampled only in IDLE.
REQ-020 IDLE with latched op not in {001,010,011}: SHALL go directly to COMPLETE; no bus_valid, no mem_req, data_out unchanged.
REQ-021 Legal op: IDLE -> BROADCAST; bus_valid=1, bus_op=op, bus_owner=owner for exactly that one cycle; otherwise bus_valid=0, bus_op=000, bus_owner held.
REQ-022 grant SHALL be one-hot on owner from BROADCAST through COMPLETE inclusive, 0000 in IDLE.
REQ-023 BROADCAST -> SNOOP unconditionally; snoop inputs sampled only in SNOOP.
REQ-024 SNOOP, op=011: -> COMPLETE; memory untouched, data_out unchanged.
REQ-025 SNOOP, op 001/010, snoop_abort=1: data_out <= snoop_data; if snoop_wb=1, mem_wr pulses in COMPLETE; -> COMPLETE.
REQ-026 SNOOP, op 001/010, snoop_abort=0: -> MEM_WAIT; snoop_wb without abort ignored.
REQ-027 MEM_WAIT: mem_req=1 every cycle until mem_ack; on mem_ack data_out <= mem_data, -> COMPLETE; mem_req=0 in all other states; no timeout.
REQ-028 COMPLETE: done[owner]=1 for one cycle; last_owner <= owner; -> IDLE.
REQ-029 Minimum gap: one IDLE cycle between consecutive transactions.
REQ-030 Latency from req sampled in IDLE (cycle 0): abort/invalidate path done at cycle 3; memory path done at cycle 3+N, N = MEM_WAIT cycles (N>=1).
REQ-031 Owner dropping req mid-transaction SHALL be ignored; transaction completes normally.
REQ-032 data_out SHALL hold its value until next load.

Reset
REQ-033 reset_n=0 at a rising edge SHALL force IDLE, last_owner=3, grant=0000, done=0000, bus_valid=0, bus_op=000, bus_owner=00, mem_req=0, mem_wr=0, data_out=00h, regardless of state.
REQ-034 Reset mid-MEM_WAIT SHALL drop mem_req next cycle; late mem_ack ignored in IDLE.

Verification
REQ-035 After reset, req=1111 all op 001, memory path, mem_ack each first MEM_WAIT cycle -> grants in order 0,1,2,3; each done 4 cycles after its IDLE sample.
REQ-036 req[2], op 001, snoop_abort=1, snoop_wb=1, snoop_data=A5h -> bus_valid one cycle with op 001/owner 10; mem_req never; done=0100 with data_out=A5h and mem_wr=1 same cycle.
REQ-037 req[1], op 011 -> bus_op=011 broadcast; done=0010 at cycle 3; mem_req, mem_wr never; data_out unchanged.
REQ-038 req[0], op 010, no abort, mem_ack after 5 cycles with 3Ch -> mem_req high 5 cycles; done=0001 with data_out=3Ch at cycle 8.
REQ-039 req[3], op 101 -> no bus_valid; done=1000 at cycle 1; next round-robin search starts at 0.
REQ-040 reset_n=0 during MEM_WAIT, then mem_ack=1 after release -> all outputs at reset values; no done pulse.
